// File: rtl/ballot_collect.sv
// Five-station ballot collector: one locked one-hot vote per station,
// session closes when all stations have cast or the timer runs out.
module ballot_collect #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [14:0] btn,
  output logic [2:0]  in1,
  output logic [2:0]  in2,
  output logic [2:0]  in3,
  output logic [2:0]  in4,
  output logic [2:0]  in5,
  output logic [4:0]  cast_mask,
  output logic [4:0]  err_mask,
  output logic        busy,
  output logic        valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [2:0]  ballot_q [5];
  logic [15:0] timer_q;
  logic [4:0]  cast_q;
  logic [4:0]  err_q;
  logic        busy_q;
  logic        valid_q;

  logic [4:0]  acc;
  logic [4:0]  rej;
  logic [4:0]  cast_d;
  logic [2:0]  fld;

  // Classify each station field; locked stations never accept or reject.
  always_comb begin
    acc = '0;
    rej = '0;
    fld = '0;
    for (int k = 0; k < 5; k++) begin
      fld = btn[3*k +: 3];
      if (state_q == COLLECT && !cast_q[k]) begin
        acc[k] = fld inside {3'b001, 3'b010, 3'b100};
        rej[k] = fld inside {3'b011, 3'b101, 3'b110, 3'b111};
      end
    end
  end

  assign cast_d = cast_q | acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int k = 0; k < 5; k++) ballot_q[k] <= '0;
      timer_q <= '0;
      cast_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      err_q <= '0;
      unique case (state_q)
        COLLECT: begin
          timer_q <= timer_q + 16'd1;
          err_q   <= rej;
          cast_q  <= cast_d;
          for (int k = 0; k < 5; k++)
            if (acc[k]) ballot_q[k] <= btn[3*k +: 3];
          if (cast_d == 5'h1f || timer_q == TLAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        IDLE, DONE: begin
          if (start) begin
            state_q <= COLLECT;
            for (int k = 0; k < 5; k++) ballot_q[k] <= '0;
            timer_q <= '0;
            cast_q  <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in1       = ballot_q[0];
  assign in2       = ballot_q[1];
  assign in3       = ballot_q[2];
  assign in4       = ballot_q[3];
  assign in5       = ballot_q[4];
  assign cast_mask = cast_q;
  assign err_mask  = err_q;
  assign busy      = busy_q;
  assign valid     = valid_q;

endmodule

// File: doc/ballot_collect.md
BALLOT_COLLECT -- requirements
Module: ballot_collect

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000: number of COLLECT-state cycles before the session closes; legal range 2 to 65535.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: open a new voting session.
REQ-005 SHALL have port btn, input, 15: station k (k = 1..5) buttons on bits [3k-1:3k-3]; one bit per candidate, bit0 = candidate A.
REQ-006 SHALL have ports in1, in2, in3, in4 and in5, each output, 3: registered one-hot ballot per station; 3'b000 = not cast; feeds the vote block directly.
REQ-007 SHALL have port cast_mask, output, 5: bit k-1 = station k has cast its ballot.
REQ-008 SHALL have port err_mask, output, 5: one-cycle pulse per station on a rejected multi-bit press.
REQ-009 SHALL have port busy, output, 1: session in COLLECT.
REQ-010 SHALL have port valid, output, 1: ballots final and stable.

Function
REQ-011 SHALL implement a 3-state FSM.
- IDLE -> COLLECT on start.
- COLLECT -> DONE on close (REQ-016).
- DONE -> COLLECT on start.
- No other transitions.
REQ-012 On entry to COLLECT, SHALL clear in1..in5 to 3'b000, clear cast_mask to 0, and clear the timer to 0 at the same edge.
REQ-013 In COLLECT, a station's press SHALL be accepted when all of the following hold in that cycle: its 3-bit field is exactly one-hot, and its cast_mask bit is 0.
- On acceptance, the field is latched into the station's in register at the next edge (latency 1).
- The station's cast_mask bit is set at that same edge.
REQ-014 A press with 2 or 3 bits set SHALL be ignored.
- The station's err_mask bit is high for exactly the following cycle.
- The station remains uncast.
REQ-015 A cast ballot SHALL be locked: later presses from that station, valid or not, produce no change and no err pulse.
REQ-016 The timer SHALL increment by 1 each COLLECT cycle, with width 16 bits. Close occurs at the edge where either condition holds:
- all five stations are cast after that edge's accepts;
- the timer equals TIMEOUT-1.
REQ-017 Presses accepted in the closing cycle SHALL be latched.
REQ-018 Simultaneous presses from multiple stations in one cycle SHALL all be accepted independently.
REQ-019 busy SHALL be high exactly while the state is COLLECT.
REQ-020 valid SHALL be high exactly while the state is DONE; it rises on the same edge the final ballot is latched.
REQ-021 In DONE, in1..in5 and cast_mask SHALL hold unchanged; btn SHALL be ignored.
REQ-022 Uncast stations SHALL present 3'b000 in DONE.
REQ-023 start while in COLLECT SHALL be ignored: no restart and no timer clear.
REQ-024 btn in IDLE SHALL be ignored, with no err pulses.
REQ-025 All outputs SHALL be driven from registers; there is no combinational path from btn to any output.

Reset
REQ-026 When rst is high at a rising edge, all of the following SHALL apply at that edge:
- state = IDLE;
- in1..in5 = 3'b000;
- cast_mask = 0;
- err_mask = 0;
- timer = 0;
- busy = 0;
- valid = 0.
REQ-027 rst SHALL take priority over start and btn in the same cycle.
REQ-028 rst asserted mid-COLLECT or in DONE SHALL discard the session completely.

Verification
REQ-029 The bench SHALL cover a full vote.
- Stimulus: start; then one press per cycle, stations 1..5 pressing 001, 010, 010, 100, 010.
- Response: valid rises the edge after the station-5 press, with in1..in5 = 001, 010, 010, 100, 010 and cast_mask = 11111.
REQ-030 The bench SHALL cover timeout.
- Stimulus: TIMEOUT = 8; start; only stations 1 and 3 press 100.
- Response: valid rises 8 cycles after COLLECT entry, with in2, in4 and in5 = 000 and cast_mask = 00101.
REQ-031 The bench SHALL cover a rejected press followed by a retry.
- Stimulus: station 2 presses 011, then 010.
- Response: err_mask = 00010 for one cycle; then in2 = 010.
REQ-032 The bench SHALL cover lock and simultaneous presses.
- Stimulus: stations 1 and 4 press 001 in the same cycle; station 1 later presses 100.
- Response: both are cast; in1 stays 001.
REQ-033 The bench SHALL cover restart and reset.
- Stimulus: start in DONE; then rst asserted mid-COLLECT.
- Response: ballots clear to 000; busy = 1 until the rst edge; then IDLE, with all outputs 0.
REQ-034 The bench SHALL cover a cast on the closing cycle.
- Stimulus: TIMEOUT = 4; station 5 presses on the cycle the timer equals 3.
- Response: in5 is latched, and valid rises on that same edge.
